// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pacman_pkg
//  Brief   : Shared types and constants for the Pac-Man board write path.
//  Rev     : 1.0  initial release
// ============================================================================
package pacman_pkg;

  // Sprite requester indices
  typedef enum logic [2:0] {
    SPR_PAC    = 3'd0,
    SPR_BLINKY = 3'd1,
    SPR_CLYDE  = 3'd2,
    SPR_INKY   = 3'd3,
    SPR_PINKY  = 3'd4
  } sprite_e;

  localparam int         NUM_SPRITES = 5;
  localparam int         CELLS       = 768;     // 32x24 blocks
  localparam logic [3:0] ERASE_TYPE  = 4'h0;
  localparam int         LOC_W       = 10;
  localparam int         TYPE_W      = 4;
  localparam logic [9:0] LOC_NONE    = 10'h3FF; // "not on the board yet"

  // Write scheduler sequence
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // True when a location addresses a real board cell
  function automatic logic loc_ok(input logic [LOC_W-1:0] loc, input int unsigned cells);
    return {{(32-LOC_W){1'b0}}, loc} < cells;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_write_sched_if.sv
`default_nettype none
// ============================================================================
//  Module  : board_write_sched_if
//  Brief   : Sprite request bundle and board RAM write port of the scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
interface board_write_sched_if import pacman_pkg::*; #(
  parameter int NREQ = NUM_SPRITES
);
  logic                              blank;
  logic [NREQ-1:0]                   req;
  logic [NREQ-1:0][LOC_W-1:0]        old_loc;
  logic [NREQ-1:0][LOC_W-1:0]        new_loc;
  logic [NREQ-1:0][TYPE_W-1:0]       sprite_type;
  logic [NREQ-1:0]                   ack;
  logic [LOC_W-1:0]                  ram_addr;
  logic [TYPE_W-1:0]                 ram_data;
  logic                              ram_wren;
  logic                              wr_active;
  logic                              collide;
  logic                              bad_loc;

  // Sprite logic / video side
  modport master (
    output blank, req, old_loc, new_loc, sprite_type,
    input  ack, ram_addr, ram_data, ram_wren, wr_active, collide, bad_loc
  );

  // Scheduler side
  modport slave (
    input  blank, req, old_loc, new_loc, sprite_type,
    output ack, ram_addr, ram_data, ram_wren, wr_active, collide, bad_loc
  );
endinterface
`default_nettype wire

// File: rtl/board_write_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Brief   : Round-robin one-hot grant, searching upward from ptr and wrapping.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ  = 5,
  parameter int PTR_W = 3
) (
  input  wire logic [NREQ-1:0]  req,
  input  wire logic [PTR_W-1:0] ptr,
  output logic      [NREQ-1:0]  grant
);

  // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_write_sched.sv
`default_nettype none
// ============================================================================
//  Module  : board_write_sched
//  Brief   : Serialises sprite moves into board RAM: erase the old cell, draw
//            the new one, then acknowledge. Writes only start during blank.
//  Rev     : 1.0  initial release
// ============================================================================
module board_write_sched import pacman_pkg::*; #(
  parameter int         NREQ       = NUM_SPRITES,
  parameter int         CELLS      = pacman_pkg::CELLS,
  parameter logic [3:0] ERASE_TYPE = pacman_pkg::ERASE_TYPE
) (
  input  wire logic          clk,
  input  wire logic          reset,   // asynchronous, active low
  board_write_sched_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                      state_q, state_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [PTR_W-1:0]            idx_q, idx_d;
  logic [LOC_W-1:0]            old_q, old_d;
  logic [LOC_W-1:0]            new_q, new_d;
  logic [TYPE_W-1:0]           type_q, type_d;
  logic [NREQ-1:0]             ack_q, ack_d;
  logic [LOC_W-1:0]            addr_q, addr_d;
  logic [TYPE_W-1:0]           data_q, data_d;
  logic                        wren_q, wren_d;
  logic                        active_q, active_d;
  logic                        collide_q, collide_d;
  logic                        bad_q, bad_d;
  logic [NREQ-1:0][LOC_W-1:0]  pos_q, pos_d;

  logic [NREQ-1:0]             w_grant;
  logic [PTR_W-1:0]            w_gnt_idx;
  logic [PTR_W-1:0]            w_next_ptr;
  logic [LOC_W-1:0]            w_sel_old;
  logic [LOC_W-1:0]            w_sel_new;
  logic [TYPE_W-1:0]           w_sel_type;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (w_grant)
  );

  // Turn the one-hot grant into an index and pick that sprite's inputs
  always_comb begin
    w_gnt_idx  = '0;
    w_sel_old  = '0;
    w_sel_new  = '0;
    w_sel_type = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx  = PTR_W'(i);
        w_sel_old  = bus.old_loc[i];
        w_sel_new  = bus.new_loc[i];
        w_sel_type = bus.sprite_type[i];
      end
    end
    w_next_ptr = (w_gnt_idx == PTR_W'(NREQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
  end

  // Next-state and next-output logic; outputs are registered on entry to a state
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    old_d     = old_q;
    new_d     = new_q;
    type_d    = type_q;
    ack_d     = '0;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    active_d  = 1'b0;
    collide_d = collide_q;
    bad_d     = bad_q;
    pos_d     = pos_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.blank && (|bus.req)) begin
          state_d  = ST_ERASE;
          ptr_d    = w_next_ptr;
          idx_d    = w_gnt_idx;
          old_d    = w_sel_old;
          new_d    = w_sel_new;
          type_d   = w_sel_type;
          active_d = 1'b1;
          addr_d   = w_sel_old;
          data_d   = ERASE_TYPE;
          // Erasing a cell we are about to redraw is pointless
          if (w_sel_old != w_sel_new) begin
            if (loc_ok(w_sel_old, CELLS)) wren_d = 1'b1;
            else                          bad_d  = 1'b1;
          end
        end
      end
      ST_ERASE: begin
        state_d  = ST_DRAW;
        active_d = 1'b1;
        addr_d   = new_q;
        data_d   = type_q;
        if (loc_ok(new_q, CELLS)) wren_d = 1'b1;
        else                      bad_d  = 1'b1;
      end
      ST_DRAW: begin
        state_d = ST_ACK;
        for (int i = 0; i < NREQ; i++) ack_d[i] = (idx_q == PTR_W'(i));
        // Only a sprite that really landed on the board is remembered
        if (loc_ok(new_q, CELLS)) begin
          if (idx_q == PTR_W'(SPR_PAC)) begin
            for (int g = 1; g < NREQ; g++) begin
              if (pos_q[g] == new_q) collide_d = 1'b1;
            end
          end else if (pos_q[SPR_PAC] == new_q) begin
            collide_d = 1'b1;
          end
          for (int i = 0; i < NREQ; i++) begin
            if (idx_q == PTR_W'(i)) pos_d[i] = new_q;
          end
        end
      end
      ST_ACK: begin
        // Requests seen here belong to the sprite just acked; never regrant
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      old_q     <= '0;
      new_q     <= '0;
      type_q    <= '0;
      ack_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      active_q  <= 1'b0;
      collide_q <= 1'b0;
      bad_q     <= 1'b0;
      pos_q     <= {NREQ{LOC_NONE}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      old_q     <= old_d;
      new_q     <= new_d;
      type_q    <= type_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      active_q  <= active_d;
      collide_q <= collide_d;
      bad_q     <= bad_d;
      pos_q     <= pos_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_data  = data_q;
  assign bus.ram_wren  = wren_q;
  assign bus.wr_active = active_q;
  assign bus.collide   = collide_q;
  assign bus.bad_loc   = bad_q;

endmodule
`default_nettype wire
